// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetched instruction, captures register-file
// operands and holds them in the ID/EX register. Also owns load-use hazard
// detection, flush handling and bubble insertion.
module id_stage #(
  parameter logic [31:0] BUBBLE_INST = 32'hffffffff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] rs1_val_o,
  output logic [31:0] rs2_val_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rd_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_a_pc_o,
  output logic        alu_b_imm_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [1:0]  mem_size_o,
  output logic        mem_uns_o,
  output logic [2:0]  branch_o,
  output logic        is_br_o,
  output logic        is_jal_o,
  output logic        is_jalr_o,
  output logic        illegal_o
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_MISC   = 7'b0001111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_a_pc;
    logic        alu_b_imm;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic        mem_uns;
    logic [2:0]  branch;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
  } idex_t;

  idex_t       ex_q;
  idex_t       dec;
  logic        illegal_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd_field;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic        legal;
  logic        use_rs1;
  logic        use_rs2;
  logic        is_bubble_word;
  logic        take_bubble;
  logic        illegal_seen;
  logic        hazard;

  assign opcode   = inst_i[6:0];
  assign funct3   = inst_i[14:12];
  assign rs1      = inst_i[19:15];
  assign rs2      = inst_i[24:20];
  assign rd_field = inst_i[11:7];

  assign rs1_addr_o = rs1;
  assign rs2_addr_o = rs2;

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                  inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'h000};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                  inst_i[30:21], 1'b0};

  assign is_bubble_word = (inst_i == BUBBLE_INST);

  // Map funct3 (plus bit 30 for shifts/SUB) onto the ALU operation.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                input logic       b30,
                                                input logic       is_reg);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (is_reg && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Combinational decode of the presented instruction into an ID/EX image.
  always_comb begin
    dec          = '0;
    legal        = 1'b1;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    dec.valid    = 1'b1;
    dec.pc       = pc_i;
    dec.rs1_val  = (rs1 == 5'd0) ? '0 : rs1_data_i;
    dec.rs2_val  = (rs2 == 5'd0) ? '0 : rs2_data_i;

    case (opcode)
      OPC_LUI: begin
        dec.rd        = rd_field;
        dec.imm       = imm_u;
        dec.alu_op    = ALU_PASSB;
        dec.alu_b_imm = 1'b1;
      end
      OPC_AUIPC: begin
        dec.rd        = rd_field;
        dec.imm       = imm_u;
        dec.alu_op    = ALU_ADD;
        dec.alu_a_pc  = 1'b1;
        dec.alu_b_imm = 1'b1;
      end
      // Link value pc+4 is formed by execute; imm carries the target offset.
      OPC_JAL: begin
        dec.rd       = rd_field;
        dec.imm      = imm_j;
        dec.alu_op   = ALU_ADD;
        dec.alu_a_pc = 1'b1;
        dec.is_jal   = 1'b1;
      end
      OPC_JALR: begin
        use_rs1      = 1'b1;
        dec.rd       = rd_field;
        dec.imm      = imm_i;
        dec.alu_op   = ALU_ADD;
        dec.alu_a_pc = 1'b1;
        dec.is_jalr  = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.imm    = imm_b;
        dec.alu_op = ALU_SUB;
        dec.branch = funct3;
        dec.is_br  = 1'b1;
      end
      OPC_LOAD: begin
        use_rs1       = 1'b1;
        dec.rd        = rd_field;
        dec.imm       = imm_i;
        dec.alu_op    = ALU_ADD;
        dec.alu_b_imm = 1'b1;
        dec.mem_rd    = 1'b1;
        dec.mem_size  = funct3[1:0];
        dec.mem_uns   = funct3[2];
      end
      OPC_STORE: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.imm       = imm_s;
        dec.alu_op    = ALU_ADD;
        dec.alu_b_imm = 1'b1;
        dec.mem_wr    = 1'b1;
        dec.mem_size  = funct3[1:0];
      end
      OPC_OPIMM: begin
        use_rs1       = 1'b1;
        dec.rd        = rd_field;
        dec.imm       = imm_i;
        dec.alu_op    = alu_from_funct(funct3, inst_i[30], 1'b0);
        dec.alu_b_imm = 1'b1;
      end
      OPC_OP: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.rd     = rd_field;
        dec.alu_op = alu_from_funct(funct3, inst_i[30], 1'b1);
      end
      // FENCE, ECALL and EBREAK flow through as valid no-ops.
      OPC_MISC, OPC_SYSTEM: begin
        dec.rd = 5'd0;
      end
      default: begin
        legal = 1'b0;
      end
    endcase

    // Unused source operands never match a bubble word or invalid slot.
    if (!inst_valid_i || is_bubble_word) begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end

    take_bubble  = !inst_valid_i || is_bubble_word || !legal;
    illegal_seen = inst_valid_i && !is_bubble_word && !legal;
    if (take_bubble) begin
      dec = '0;
    end
  end

  // Load-use hazard against the load currently sitting in ID/EX.
  always_comb begin
    hazard = ex_q.valid && ex_q.mem_rd && (ex_q.rd != 5'd0) && inst_valid_i &&
             ((use_rs1 && (ex_q.rd == rs1)) || (use_rs2 && (ex_q.rd == rs2)));
  end

  // A flush consumes and drops the presented word, so it reports ready.
  assign ready_o = rdy && (flush_i || (!stall_i && !hazard));

  // ID/EX register and sticky illegal flag, priority rst > flush > stall > hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
    end else if (rdy) begin
      if (flush_i) begin
        ex_q <= '0;
      end else if (stall_i) begin
        ex_q <= ex_q;
      end else if (hazard) begin
        ex_q <= '0;
      end else begin
        ex_q <= dec;
        if (illegal_seen) begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

  assign valid_o     = ex_q.valid;
  assign pc_o        = ex_q.pc;
  assign rs1_val_o   = ex_q.rs1_val;
  assign rs2_val_o   = ex_q.rs2_val;
  assign imm_o       = ex_q.imm;
  assign rd_o        = ex_q.rd;
  assign alu_op_o    = ex_q.alu_op;
  assign alu_a_pc_o  = ex_q.alu_a_pc;
  assign alu_b_imm_o = ex_q.alu_b_imm;
  assign mem_rd_o    = ex_q.mem_rd;
  assign mem_wr_o    = ex_q.mem_wr;
  assign mem_size_o  = ex_q.mem_size;
  assign mem_uns_o   = ex_q.mem_uns;
  assign branch_o    = ex_q.branch;
  assign is_br_o     = ex_q.is_br;
  assign is_jal_o    = ex_q.is_jal;
  assign is_jalr_o   = ex_q.is_jalr;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with hand-computed expectations.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        inst_valid_i;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        ready_o;
  logic        stall_i;
  logic        flush_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] rs1_val_o;
  logic [31:0] rs2_val_o;
  logic [31:0] imm_o;
  logic [4:0]  rd_o;
  logic [3:0]  alu_op_o;
  logic        alu_a_pc_o;
  logic        alu_b_imm_o;
  logic        mem_rd_o;
  logic        mem_wr_o;
  logic [1:0]  mem_size_o;
  logic        mem_uns_o;
  logic [2:0]  branch_o;
  logic        is_br_o;
  logic        is_jal_o;
  logic        is_jalr_o;
  logic        illegal_o;

  int unsigned vectors;
  int unsigned miscompares;

  id_stage #(.BUBBLE_INST(32'hffffffff)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .inst_valid_i(inst_valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .ready_o(ready_o), .stall_i(stall_i), .flush_i(flush_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .valid_o(valid_o), .pc_o(pc_o), .rs1_val_o(rs1_val_o),
    .rs2_val_o(rs2_val_o), .imm_o(imm_o), .rd_o(rd_o),
    .alu_op_o(alu_op_o), .alu_a_pc_o(alu_a_pc_o), .alu_b_imm_o(alu_b_imm_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_size_o(mem_size_o),
    .mem_uns_o(mem_uns_o), .branch_o(branch_o), .is_br_o(is_br_o),
    .is_jal_o(is_jal_o), .is_jalr_o(is_jalr_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic v, input logic [31:0] pc,
                         input logic [31:0] inst);
    inst_valid_i = v;
    pc_i         = pc;
    inst_i       = inst;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    rdy          = 1'b1;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    rs1_data_i   = '0;
    rs2_data_i   = '0;
    present(1'b0, 32'h0, 32'hffffffff);
    cyc();
    cyc();

    // Reset state
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_imm", imm_o, 32'd0);
    chk("rst_rd", {27'd0, rd_o}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);

    // ADDI x1,x0,5 ; rs1 is x0 so its value must read as zero
    present(1'b1, 32'h0, 32'h00500093);
    rs1_data_i = 32'hdeadbeef;
    #1;
    chk("addi_rs1addr", {27'd0, rs1_addr_o}, 32'd0);
    cyc();
    chk("addi_valid", {31'd0, valid_o}, 32'd1);
    chk("addi_rd", {27'd0, rd_o}, 32'd1);
    chk("addi_imm", imm_o, 32'd5);
    chk("addi_alu", {28'd0, alu_op_o}, 32'd0);
    chk("addi_bimm", {31'd0, alu_b_imm_o}, 32'd1);
    chk("addi_rs1val", rs1_val_o, 32'd0);

    // LW x2,0(x1)
    present(1'b1, 32'h4, 32'h0000a103);
    rs1_data_i = 32'd5;
    #1;
    chk("lw_ready", {31'd0, ready_o}, 32'd1);
    cyc();
    chk("lw_memrd", {31'd0, mem_rd_o}, 32'd1);
    chk("lw_rd", {27'd0, rd_o}, 32'd2);
    chk("lw_size", {30'd0, mem_size_o}, 32'd2);
    chk("lw_rs1val", rs1_val_o, 32'd5);

    // ADD x3,x2,x1 right behind the load: one bubble
    present(1'b1, 32'h8, 32'h001101b3);
    rs1_data_i = 32'h11;
    rs2_data_i = 32'd5;
    #1;
    chk("lu_ready_lo", {31'd0, ready_o}, 32'd0);
    cyc();
    chk("lu_bubble", {31'd0, valid_o}, 32'd0);
    chk("lu_bubble_rd", {27'd0, rd_o}, 32'd0);
    chk("lu_ready_hi", {31'd0, ready_o}, 32'd1);
    cyc();
    chk("add_valid", {31'd0, valid_o}, 32'd1);
    chk("add_rd", {27'd0, rd_o}, 32'd3);
    chk("add_pc", pc_o, 32'h8);
    chk("add_bimm", {31'd0, alu_b_imm_o}, 32'd0);
    chk("add_rs1val", rs1_val_o, 32'h11);
    chk("add_rs2val", rs2_val_o, 32'd5);

    // BEQ x1,x2,-8
    present(1'b1, 32'hc, 32'hfe208ce3);
    cyc();
    chk("beq_isbr", {31'd0, is_br_o}, 32'd1);
    chk("beq_branch", {29'd0, branch_o}, 32'd0);
    chk("beq_rd", {27'd0, rd_o}, 32'd0);
    chk("beq_imm", imm_o, 32'hfffffff8);

    // SUB x3,x2,x1
    present(1'b1, 32'h10, 32'h401101b3);
    cyc();
    chk("sub_alu", {28'd0, alu_op_o}, 32'd1);

    // LUI x4,0x12345
    present(1'b1, 32'h14, 32'h12345237);
    cyc();
    chk("lui_imm", imm_o, 32'h12345000);
    chk("lui_alu", {28'd0, alu_op_o}, 32'd10);
    chk("lui_rd", {27'd0, rd_o}, 32'd4);

    // JAL x1,+16
    present(1'b1, 32'h18, 32'h010000ef);
    cyc();
    chk("jal_isjal", {31'd0, is_jal_o}, 32'd1);
    chk("jal_apc", {31'd0, alu_a_pc_o}, 32'd1);
    chk("jal_imm", imm_o, 32'd16);
    chk("jal_rd", {27'd0, rd_o}, 32'd1);

    // Bubble word, then illegal all-zero word
    present(1'b1, 32'h1c, 32'hffffffff);
    cyc();
    chk("bw_valid", {31'd0, valid_o}, 32'd0);
    chk("bw_illegal", {31'd0, illegal_o}, 32'd0);
    present(1'b1, 32'h1c, 32'h00000000);
    cyc();
    chk("ill_valid", {31'd0, valid_o}, 32'd0);
    chk("ill_flag", {31'd0, illegal_o}, 32'd1);

    // ADDI x1,x0,5 at 0x20, then stall for 3 cycles
    present(1'b1, 32'h20, 32'h00500093);
    cyc();
    chk("ill_sticky", {31'd0, illegal_o}, 32'd1);
    chk("st_valid0", {31'd0, valid_o}, 32'd1);
    present(1'b1, 32'h24, 32'h00700293);
    stall_i = 1'b1;
    #1;
    chk("st_ready", {31'd0, ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("st_pc", pc_o, 32'h20);
      chk("st_imm", imm_o, 32'd5);
      chk("st_rd", {27'd0, rd_o}, 32'd1);
    end

    // Flush during stall wins
    flush_i = 1'b1;
    #1;
    chk("fl_ready", {31'd0, ready_o}, 32'd1);
    cyc();
    chk("fl_valid", {31'd0, valid_o}, 32'd0);
    flush_i = 1'b0;
    stall_i = 1'b0;
    cyc();
    chk("x5_rd", {27'd0, rd_o}, 32'd5);
    chk("x5_imm", imm_o, 32'd7);

    // rdy low for two cycles with ADDI x6,x0,9 presented
    present(1'b1, 32'h30, 32'h00900313);
    rdy = 1'b0;
    #1;
    chk("rdy_ready", {31'd0, ready_o}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rdy_pc", pc_o, 32'h24);
      chk("rdy_rd", {27'd0, rd_o}, 32'd5);
      chk("rdy_valid", {31'd0, valid_o}, 32'd1);
    end
    rdy = 1'b1;
    cyc();
    chk("x6_pc", pc_o, 32'h30);
    chk("x6_rd", {27'd0, rd_o}, 32'd6);
    chk("x6_imm", imm_o, 32'd9);
    chk("ill_final", {31'd0, illegal_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
